fetch_seq: RTL and testbench

Instruction-sequencing controller for the 8-bit CPU. It owns the control inputs of the PC/PC-mux block (`write_pc`, `PC_sel`) and the instruction-register load. It steps the core through fetch, decode, execute and branch, handshaking with instruction memory. It sits between the instruction register/flags and the PC, the memory read port and the register file/ALU enables.

---
 rtl/fetch_seq.sv | 174 +++++++++++++++++
 tb/tb_fetch_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-sequencing controller for the 8-bit CPU.
// Steps the core through FETCH/DECODE/EXEC/BRANCH, handshakes with the
// instruction memory, and drives the PC write/select and IR load strobes.
// Optional single-step support is enabled by defining FETCH_SEQ_STEP_EN.
module fetch_seq #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk_seq,
    input  logic       rstn_seq,
`ifdef FETCH_SEQ_STEP_EN
    input  logic       step_mode,
    input  logic       step,
`endif
    input  logic       run,
    input  logic       resume,
    input  logic       mem_ready,
    input  logic [3:0] ir_opcode,
    input  logic       zero_flag,
    output logic       mem_rd,
    output logic       ir_load,
    output logic       write_pc,
    output logic       PC_sel,
    output logic       cbus_tgt_oe,
    output logic       alu_en,
    output logic       reg_wr,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] icount
);

    localparam int unsigned WAIT_W   = 4;
    localparam int unsigned ICOUNT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_BRANCH = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6,
        S_STEP   = 3'd7
    } state_t;

    state_t            cur_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              step_hold;
    logic              step_go;
    logic              is_alu;
    state_t            retire_state;

`ifdef FETCH_SEQ_STEP_EN
    assign step_hold = step_mode;
    assign step_go   = step;
`else
    assign step_hold = 1'b0;
    assign step_go   = 1'b0;
`endif

    // Opcodes 0x1..0x7 are ALU operations
    assign is_alu       = (ir_opcode != 4'h0) && !ir_opcode[3];
    assign retire_state = step_hold ? S_STEP : S_FETCH;
    assign state        = cur_state;

    // Sequencer state, wait counter, fault flag and retirement counter
    always_ff @(posedge clk_seq) begin
        if (!rstn_seq) begin
            cur_state <= S_IDLE;
            wait_cnt  <= '0;
            fault     <= 1'b0;
            icount    <= '0;
        end else begin
            if (cur_state != S_FETCH) begin
                wait_cnt <= '0;
            end
            case (cur_state)
                S_IDLE: begin
                    if (run) begin
                        cur_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        cur_state <= S_DECODE;
                        wait_cnt  <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur_state <= S_FAULT;
                        fault     <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    case (ir_opcode)
                        4'h8: cur_state <= S_BRANCH;
                        4'h9: begin
                            if (zero_flag) begin
                                cur_state <= S_BRANCH;
                            end else begin
                                cur_state <= retire_state;
                                icount    <= icount + ICOUNT_W'(1);
                            end
                        end
                        4'hA: begin
                            if (!zero_flag) begin
                                cur_state <= S_BRANCH;
                            end else begin
                                cur_state <= retire_state;
                                icount    <= icount + ICOUNT_W'(1);
                            end
                        end
                        4'hF: begin
                            cur_state <= S_HALT;
                            icount    <= icount + ICOUNT_W'(1);
                        end
                        default: cur_state <= S_EXEC;
                    endcase
                end
                S_EXEC, S_BRANCH: begin
                    cur_state <= retire_state;
                    icount    <= icount + ICOUNT_W'(1);
                end
                S_HALT: begin
                    if (resume) begin
                        cur_state <= S_FETCH;
                    end
                end
                S_FAULT: begin
                    if (resume) begin
                        cur_state <= S_FETCH;
                        fault     <= 1'b0;
                    end
                end
                S_STEP: begin
                    if (step_go) begin
                        cur_state <= S_FETCH;
                    end
                end
                default: cur_state <= S_IDLE;
            endcase
        end
    end

    // Strobe decode from the state register; FETCH accept also follows mem_ready
    always_comb begin
        mem_rd      = 1'b0;
        ir_load     = 1'b0;
        write_pc    = 1'b0;
        PC_sel      = 1'b0;
        cbus_tgt_oe = 1'b0;
        alu_en      = 1'b0;
        reg_wr      = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_rd   = 1'b1;
                ir_load  = mem_ready;
                write_pc = mem_ready;
            end
            S_EXEC: begin
                alu_en = is_alu;
                reg_wr = is_alu;
            end
            S_BRANCH: begin
                cbus_tgt_oe = 1'b1;
                PC_sel      = 1'b1;
                write_pc    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized instruction stream against an instruction-level
// reference model that expands each instruction into its expected cycle trace.
module tb_fetch_seq;

    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_MRD   = 7'b1000000;
    localparam logic [6:0] S_IRL   = 7'b0100000;
    localparam logic [6:0] S_WPC   = 7'b0010000;
    localparam logic [6:0] S_PCSEL = 7'b0001000;
    localparam logic [6:0] S_CBUS  = 7'b0000100;
    localparam logic [6:0] S_ALU   = 7'b0000010;
    localparam logic [6:0] S_REGWR = 7'b0000001;

    logic       clk_seq;
    logic       rstn_seq;
    logic       run;
    logic       resume;
    logic       mem_ready;
    logic [3:0] ir_opcode;
    logic       zero_flag;
    logic       mem_rd;
    logic       ir_load;
    logic       write_pc;
    logic       PC_sel;
    logic       cbus_tgt_oe;
    logic       alu_en;
    logic       reg_wr;
    logic       fault;
    logic [2:0] state;
    logic [7:0] icount;
`ifdef FETCH_SEQ_STEP_EN
    logic       step_mode;
    logic       step;
`endif

    logic [18:0] outs;
    int          n_checks;
    int          n_errors;
    int          n_regwr;
    int          n_wpc;
    logic [7:0]  m_icount;
    bit          m_step;

    fetch_seq #(.MEM_WAIT_MAX(15)) dut (
        .clk_seq    (clk_seq),
        .rstn_seq   (rstn_seq),
`ifdef FETCH_SEQ_STEP_EN
        .step_mode  (step_mode),
        .step       (step),
`endif
        .run        (run),
        .resume     (resume),
        .mem_ready  (mem_ready),
        .ir_opcode  (ir_opcode),
        .zero_flag  (zero_flag),
        .mem_rd     (mem_rd),
        .ir_load    (ir_load),
        .write_pc   (write_pc),
        .PC_sel     (PC_sel),
        .cbus_tgt_oe(cbus_tgt_oe),
        .alu_en     (alu_en),
        .reg_wr     (reg_wr),
        .fault      (fault),
        .state      (state),
        .icount     (icount)
    );

    assign outs = {mem_rd, ir_load, write_pc, PC_sel, cbus_tgt_oe, alu_en, reg_wr,
                   fault, state, icount};

    initial clk_seq = 1'b0;
    always #5 clk_seq = ~clk_seq;

    function automatic logic [18:0] ev(input logic [6:0] s, input logic f,
                                       input logic [2:0] st, input logic [7:0] ic);
        return {s, f, st, ic};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Compare one cycle mid-period, then advance to just after the next rising edge
    task automatic tick_check(input string tag, input logic [18:0] exp);
        @(negedge clk_seq);
        if (reg_wr === 1'b1) n_regwr++;
        if (write_pc === 1'b1) n_wpc++;
        check(tag, 32'(outs), 32'(exp));
        @(posedge clk_seq);
        #1;
    endtask

`ifdef FETCH_SEQ_STEP_EN
    task automatic step_wait();
        int k;
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) tick_check("step_hold", ev(S_NONE, 1'b0, 3'd7, m_icount));
        step = 1'b1;
        tick_check("step_go", ev(S_NONE, 1'b0, 3'd7, m_icount));
        step = 1'b0;
    endtask
`endif

    task automatic after_retire();
`ifdef FETCH_SEQ_STEP_EN
        if (m_step) step_wait();
`endif
    endtask

    // One instruction starting in FETCH: expected trace from opcode class and latency rules
    task automatic do_instr(input logic [3:0] op, input logic zf, input int waits);
        bit is_alu;
        bit is_jump;
        bit taken;
        int k;
        is_alu  = (op >= 4'h1) && (op <= 4'h7);
        is_jump = (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
        taken   = (op == 4'h8) || (op == 4'h9 && zf) || (op == 4'hA && !zf);
        zero_flag = zf;
        mem_ready = 1'b0;
        for (int i = 0; i < waits; i++)
            tick_check("fetch_wait", ev(S_MRD, 1'b0, 3'd1, m_icount));
        mem_ready = 1'b1;
        tick_check("fetch_accept", ev(S_MRD | S_IRL | S_WPC, 1'b0, 3'd1, m_icount));
        ir_opcode = op;
        mem_ready = 1'($urandom);
        resume    = 1'($urandom);
        tick_check("decode", ev(S_NONE, 1'b0, 3'd2, m_icount));
        resume = 1'b0;
        if (op == 4'hF) begin
            m_icount = m_icount + 8'd1;
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) begin
                run       = 1'($urandom);
                mem_ready = 1'($urandom);
                tick_check("halt_hold", ev(S_NONE, 1'b0, 3'd5, m_icount));
            end
            run    = 1'b1;
            resume = 1'b1;
            tick_check("halt_resume", ev(S_NONE, 1'b0, 3'd5, m_icount));
            resume = 1'b0;
        end else if (is_jump && !taken) begin
            m_icount = m_icount + 8'd1;
            after_retire();
        end else if (taken) begin
            tick_check("branch", ev(S_PCSEL | S_WPC | S_CBUS, 1'b0, 3'd4, m_icount));
            m_icount = m_icount + 8'd1;
            after_retire();
        end else begin
            tick_check("exec", ev(is_alu ? (S_ALU | S_REGWR) : S_NONE, 1'b0, 3'd3, m_icount));
            m_icount = m_icount + 8'd1;
            after_retire();
        end
    endtask

    // Fetch timeout: 15 unanswered cycles, then FAULT until resume
    task automatic do_fault();
        int k;
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++)
            tick_check("fault_wait", ev(S_MRD, 1'b0, 3'd1, m_icount));
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
            mem_ready = 1'($urandom);
            tick_check("fault_hold", ev(S_NONE, 1'b1, 3'd6, m_icount));
        end
        mem_ready = 1'b0;
        resume    = 1'b1;
        tick_check("fault_resume", ev(S_NONE, 1'b1, 3'd6, m_icount));
        resume = 1'b0;
    endtask

    initial begin
        logic [3:0] op;
        int         waits;
        int         guard;
        n_checks  = 0;
        n_errors  = 0;
        n_regwr   = 0;
        n_wpc     = 0;
        m_icount  = 8'd0;
        m_step    = 1'b0;
        rstn_seq  = 1'b0;
        run       = 1'b0;
        resume    = 1'b0;
        mem_ready = 1'b0;
        ir_opcode = 4'h0;
        zero_flag = 1'b0;
`ifdef FETCH_SEQ_STEP_EN
        step_mode = 1'b0;
        step      = 1'b0;
`endif
        repeat (3) @(posedge clk_seq);
        #1;
        tick_check("reset", ev(S_NONE, 1'b0, 3'd0, 8'd0));
        rstn_seq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'($urandom);
            resume    = 1'($urandom);
            tick_check("idle_hold", ev(S_NONE, 1'b0, 3'd0, 8'd0));
        end
        resume = 1'b0;
        run    = 1'b1;
        tick_check("idle_run", ev(S_NONE, 1'b0, 3'd0, 8'd0));

        n_regwr = 0;
        n_wpc   = 0;
        do_instr(4'h1, 1'b0, 0);
        do_instr(4'h0, 1'b0, 0);
        do_instr(4'h3, 1'b0, 0);
        check("icount_after_3", 32'(icount), 32'd3);
        check("reg_wr_pulses", 32'(n_regwr), 32'd2);
        check("write_pc_pulses", 32'(n_wpc), 32'd3);

        n_wpc = 0;
        do_instr(4'h9, 1'b1, 0);
        check("jz_taken_wpc", 32'(n_wpc), 32'd2);
        n_wpc = 0;
        do_instr(4'h9, 1'b0, 0);
        check("jz_untaken_wpc", 32'(n_wpc), 32'd1);
        do_instr(4'hA, 1'b0, 2);
        do_instr(4'hA, 1'b1, 0);
        do_instr(4'h8, 1'b0, 14);
        do_fault();
        do_instr(4'h5, 1'b1, 1);

        guard = 0;
        while (m_icount != 8'hFF && guard < 600) begin
            op    = 4'($urandom_range(0, 15));
            waits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : 0;
            if ($urandom_range(0, 40) == 0) do_fault();
            do_instr(op, 1'($urandom), waits);
            guard++;
        end
        check("icount_pre_hlt", 32'(icount), 32'hFF);
        do_instr(4'hF, 1'b0, 0);
        check("icount_wrap", 32'(icount), 32'h00);

        // Reset during EXEC abandons the instruction
        mem_ready = 1'b1;
        tick_check("rst_fetch", ev(S_MRD | S_IRL | S_WPC, 1'b0, 3'd1, m_icount));
        ir_opcode = 4'h5;
        tick_check("rst_decode", ev(S_NONE, 1'b0, 3'd2, m_icount));
        rstn_seq = 1'b0;
        run      = 1'b0;
        tick_check("rst_exec", ev(S_ALU | S_REGWR, 1'b0, 3'd3, m_icount));
        rstn_seq = 1'b1;
        m_icount = 8'd0;
        tick_check("rst_after", ev(S_NONE, 1'b0, 3'd0, 8'd0));
        run = 1'b1;
        tick_check("rst_restart", ev(S_NONE, 1'b0, 3'd0, 8'd0));
        for (int i = 0; i < 20; i++)
            do_instr(4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 2));

`ifdef FETCH_SEQ_STEP_EN
        step_mode = 1'b1;
        m_step    = 1'b1;
        do_instr(4'h2, 1'b0, 0);
        do_instr(4'h9, 1'b0, 0);
        do_instr(4'h8, 1'b0, 1);
        for (int i = 0; i < 10; i++)
            do_instr(4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 2));
        step_mode = 1'b0;
        m_step    = 1'b0;
        do_instr(4'h4, 1'b0, 0);
`endif
        check("icount_final", 32'(icount), 32'(m_icount));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
